// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control path: sequencer state encoding,
// datapath width and reset values.
package cpu_ctrl_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  localparam state_e           STATE_RST = ST_IDLE;
  localparam logic [WIDTH-1:0] INSTR_RST = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};
  localparam logic             FLAG_RST  = 1'b0;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of PC control, instruction-memory and datapath handshake signals
// around pc_sequencer; master is the sequencer side.
interface pc_sequencer_if #(parameter int WIDTH = cpu_ctrl_pkg::WIDTH);

  logic             run;
  logic [WIDTH-1:0] pc_value;
  logic             pc_reset;
  logic             pc_load;
  logic             pc_inc;
  logic [WIDTH-1:0] pc_in;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_data;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic             exec_done;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             busy;
  logic             halted;

  modport master (
    input  run, pc_value, imem_ack, imem_data, exec_done, branch_taken, branch_target,
    output pc_reset, pc_load, pc_inc, pc_in, imem_req, imem_addr, instr, instr_valid,
           busy, halted
  );

  modport slave (
    output run, pc_value, imem_ack, imem_data, exec_done, branch_taken, branch_target,
    input  pc_reset, pc_load, pc_inc, pc_in, imem_req, imem_addr, instr, instr_valid,
           busy, halted
  );

endinterface

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute/update controller for the 16-bit CPU.
// Optional jump-to-self halt detection is enabled by defining HALT_DETECT_EN.
module pc_sequencer
  import cpu_ctrl_pkg::*;
(
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.master bus
);

  state_e           state_r;
  logic [WIDTH-1:0] instr_r;
  logic             taken_r;
  logic [WIDTH-1:0] target_r;
`ifdef HALT_DETECT_EN
  logic [WIDTH-1:0] fetch_addr_r;
`endif

  logic             imem_req_s;
  logic [WIDTH-1:0] imem_addr_s;
  logic             instr_valid_s;
  logic             pc_load_s;
  logic             pc_inc_s;
  logic [WIDTH-1:0] pc_in_s;
  logic             busy_s;
  logic             halted_s;

  // Sequencer state, instruction register and branch latches
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= STATE_RST;
      instr_r  <= INSTR_RST;
      taken_r  <= FLAG_RST;
      target_r <= WORD_ZERO;
`ifdef HALT_DETECT_EN
      fetch_addr_r <= WORD_ZERO;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.run) state_r <= ST_FETCH;
          else         state_r <= ST_IDLE;
        end
        ST_FETCH: begin
          // Request and address stay put until the memory acknowledges.
          if (bus.imem_ack) begin
            instr_r <= bus.imem_data;
`ifdef HALT_DETECT_EN
            fetch_addr_r <= bus.pc_value;
`endif
            state_r <= ST_DECODE;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_DECODE: state_r <= ST_EXEC;
        ST_EXEC: begin
          if (bus.exec_done) begin
            taken_r  <= bus.branch_taken;
            target_r <= bus.branch_target;
            state_r  <= ST_UPDATE;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_UPDATE: begin
`ifdef HALT_DETECT_EN
          // A taken jump back to its own address is the halt idiom.
          if (taken_r && (target_r == fetch_addr_r)) state_r <= ST_HALTED;
          else if (bus.run)                          state_r <= ST_FETCH;
          else                                       state_r <= ST_IDLE;
`else
          if (bus.run) state_r <= ST_FETCH;
          else         state_r <= ST_IDLE;
`endif
        end
        ST_HALTED: state_r <= ST_HALTED;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

  // Moore output decode from the state register
  always_comb begin
    imem_req_s    = 1'b0;
    imem_addr_s   = WORD_ZERO;
    instr_valid_s = 1'b0;
    pc_load_s     = 1'b0;
    pc_inc_s      = 1'b0;
    pc_in_s       = WORD_ZERO;
    busy_s        = 1'b0;
    halted_s      = 1'b0;
    case (state_r)
      ST_IDLE: busy_s = 1'b0;
      ST_FETCH: begin
        imem_req_s  = 1'b1;
        imem_addr_s = bus.pc_value;
        busy_s      = 1'b1;
      end
      ST_DECODE: begin
        instr_valid_s = 1'b1;
        busy_s        = 1'b1;
      end
      ST_EXEC: busy_s = 1'b1;
      ST_UPDATE: begin
        busy_s = 1'b1;
        if (taken_r) begin
          pc_load_s = 1'b1;
          pc_in_s   = target_r;
        end else begin
          pc_inc_s = 1'b1;
        end
      end
      ST_HALTED: begin
`ifdef HALT_DETECT_EN
        halted_s = 1'b1;
`else
        halted_s = 1'b0;
`endif
      end
      default: busy_s = 1'b0;
    endcase
  end

  // pc_reset is combinational so the PC clears on the same edge as the sequencer.
  assign bus.pc_reset    = ~reset;
  assign bus.pc_load     = pc_load_s;
  assign bus.pc_inc      = pc_inc_s;
  assign bus.pc_in       = pc_in_s;
  assign bus.imem_req    = imem_req_s;
  assign bus.imem_addr   = imem_addr_s;
  assign bus.instr       = instr_r;
  assign bus.instr_valid = instr_valid_s;
  assign bus.busy        = busy_s;
  assign bus.halted      = halted_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC beside it; a
// cycle table covers the main flow, short sequences cover reset and halt.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] pc;
  int          n_vec;
  int          n_err;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter as it sits in the CPU top
  always @(posedge clk) begin
    if (bus.pc_reset)     pc <= 16'h0000;
    else if (bus.pc_load) pc <= bus.pc_in;
    else if (bus.pc_inc)  pc <= pc + 16'h0001;
    else                  pc <= pc;
  end
  assign bus.pc_value = pc;

  typedef struct {
    logic        run;
    logic        ack;
    logic [15:0] data;
    logic        done;
    logic        tk;
    logic [15:0] tg;
    logic [69:0] exp;
  } vec_t;

  vec_t tbl [27];

  function automatic logic [69:0] ex(input logic req, input logic val, input logic ld,
                                     input logic inc, input logic bsy, input logic hlt,
                                     input logic [15:0] addr, input logic [15:0] pcin,
                                     input logic [15:0] ins, input logic [15:0] pcv);
    return {req, val, ld, inc, bsy, hlt, addr, pcin, ins, pcv};
  endfunction

  function automatic vec_t mk(input logic r, input logic a, input logic [15:0] d,
                              input logic dn, input logic t, input logic [15:0] g,
                              input logic [69:0] e);
    vec_t v;
    v.run = r; v.ack = a; v.data = d; v.done = dn; v.tk = t; v.tg = g; v.exp = e;
    return v;
  endfunction

  function automatic logic [69:0] act();
    return {bus.imem_req, bus.instr_valid, bus.pc_load, bus.pc_inc, bus.busy, bus.halted,
            bus.imem_addr, bus.pc_in, bus.instr, pc};
  endfunction

  task automatic chk(input string name, input logic [69:0] got, input logic [69:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic cyc(input logic r, input logic a, input logic [15:0] d,
                     input logic dn, input logic t, input logic [15:0] g);
    @(negedge clk);
    bus.run = r; bus.imem_ack = a; bus.imem_data = d;
    bus.exec_done = dn; bus.branch_taken = t; bus.branch_target = g;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.run = 1'b0; bus.imem_ack = 1'b0; bus.imem_data = 16'h0000;
    bus.exec_done = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 16'h0000;

    // Main flow: three straight-line instructions, a taken branch with a slow
    // fetch, then run dropped during EXEC. Each row is one cycle.
    tbl[0]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    tbl[1]  = mk(1'b1, 1'b1, 16'hA001, 1'b0, 1'b0, 16'h0000, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    tbl[2]  = mk(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA001, 16'h0000));
    tbl[3]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h00FF, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA001, 16'h0000));
    tbl[4]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA001, 16'h0000));
    tbl[5]  = mk(1'b1, 1'b1, 16'hA002, 1'b0, 1'b0, 16'h0000, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'hA001, 16'h0001));
    tbl[6]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA002, 16'h0001));
    tbl[7]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA002, 16'h0001));
    tbl[8]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA002, 16'h0001));
    tbl[9]  = mk(1'b1, 1'b1, 16'hA003, 1'b0, 1'b0, 16'h0000, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'hA002, 16'h0002));
    tbl[10] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA003, 16'h0002));
    tbl[11] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA003, 16'h0002));
    tbl[12] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA003, 16'h0002));
    tbl[13] = mk(1'b1, 1'b1, 16'hB004, 1'b0, 1'b0, 16'h0000, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'hA003, 16'h0003));
    tbl[14] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hB004, 16'h0003));
    tbl[15] = mk(1'b1, 1'b1, 16'hEEEE, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hB004, 16'h0003));
    tbl[16] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hB004, 16'h0003));
    tbl[17] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, 16'hB004, 16'h0003));
    tbl[18] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'hB004, 16'h1234));
    tbl[19] = mk(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 16'h0000, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'hB004, 16'h1234));
    tbl[20] = mk(1'b1, 1'b0, 16'h6666, 1'b0, 1'b0, 16'h0000, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'hB004, 16'h1234));
    tbl[21] = mk(1'b1, 1'b1, 16'hC005, 1'b0, 1'b0, 16'h0000, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'hB004, 16'h1234));
    tbl[22] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hC005, 16'h1234));
    tbl[23] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hC005, 16'h1234));
    tbl[24] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hC005, 16'h1234));
    tbl[25] = mk(1'b0, 1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hC005, 16'h1235));
    tbl[26] = mk(1'b0, 1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hC005, 16'h1235));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", act(), ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    chk("pc_reset_asserted", {69'd0, bus.pc_reset}, 70'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("pc_reset_released", {69'd0, bus.pc_reset}, 70'd0);

    for (int i = 0; i < 27; i++) begin
      cyc(tbl[i].run, tbl[i].ack, tbl[i].data, tbl[i].done, tbl[i].tk, tbl[i].tg);
      #1;
      chk($sformatf("vec%0d", i), act(), tbl[i].exp);
    end

    // Reset while waiting for a fetch acknowledge
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("fetch_wait", act(), ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1235, 16'h0000, 16'hC005, 16'h1235));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("pc_reset_mid_fetch", {69'd0, bus.pc_reset}, 70'd1);
    @(negedge clk);
    #1;
    chk("after_mid_reset", act(), ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    reset = 1'b1;

    // Branch to 0x0010, then a jump-to-self there
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 16'h4010, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("branch_to_10", act(), ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h4010, 16'h0000));
    cyc(1'b1, 1'b1, 16'h5010, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("fetch_10", act(), ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h4010, 16'h0010));
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("self_jump_update", act(), ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h5010, 16'h0010));
`ifdef HALT_DETECT_EN
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 16'h9999, 1'b1, 1'b0, 16'h0000);
      #1;
      chk($sformatf("halted%0d", k), act(), ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h5010, 16'h0010));
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("halt_exit_reset", act(), ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    reset = 1'b1;
`else
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b1, 16'h5010, 1'b0, 1'b0, 16'h0000);
      #1;
      chk($sformatf("refetch%0d", k), act(), ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h5010, 16'h0010));
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      #1;
      chk($sformatf("reupdate%0d", k), act(), ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h5010, 16'h0010));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/execute controller for the 16-bit CPU. It drives the program counter's reset/load/inc/in controls, fetches each instruction from instruction memory over a req/ack handshake, and holds the instruction in an instruction register. It hands each instruction to the datapath and waits for completion. It sits beside the PC in the CPU top level, between instruction memory and the ALU/datapath.

## Interface
- WIDTH, 16, address and instruction width
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- run  in  1  enable sequencing; sampled in IDLE and at end of UPDATE
- pc_value  in  WIDTH  current PC output
- pc_reset  out  1  PC reset control
- pc_load  out  1  PC load control
- pc_inc  out  1  PC increment control
- pc_in  out  WIDTH  PC load value
- imem_req  out  1  fetch request
- imem_addr  out  WIDTH  fetch address
- imem_ack  in  1  fetch data valid
- imem_data  in  WIDTH  fetched instruction
- instr  out  WIDTH  instruction register
- instr_valid  out  1  one-cycle issue pulse to datapath
- exec_done  in  1  datapath finished current instruction
- branch_taken  in  1  valid only with exec_done
- branch_target  in  WIDTH  valid only with exec_done
- busy  out  1  state != IDLE/HALTED
- halted  out  1  halt detected (see Configuration)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALTED.
- IDLE: run=1 → FETCH, otherwise stay.
- FETCH: imem_req=1, imem_addr=pc_value. Both are held stable until imem_ack=1. On the ack edge, instr<=imem_data, fetch_addr<=pc_value, → DECODE.
- imem_ack outside FETCH is ignored.
- DECODE: instr_valid=1 for exactly this cycle, → EXEC.
- EXEC: wait for exec_done=1. On that edge, latch branch_taken/branch_target, → UPDATE. exec_done may arrive in the first EXEC cycle.
- UPDATE: one cycle. Latched taken: pc_load=1, pc_in=latched target. Otherwise: pc_inc=1.
- After UPDATE: run=1 → FETCH, run=0 → IDLE.
- pc_load and pc_inc are never both 1.
- pc_in = 0 outside UPDATE-taken.
- Dropping run mid-instruction does not abort; the current instruction completes through UPDATE, then IDLE.
- PC wrap (0xFFFF+1 → 0x0000) is the PC's behaviour; the sequencer is transparent to it.

## Timing
- Reset (reset=0 at edge): state IDLE, instr=0, latches=0. All registered outputs are 0.
- pc_reset = ~reset, combinational, so the PC clears on the same edge.
- Reset mid-operation abandons the fetch or exec immediately. imem_req is 0 from the next cycle.
- pc_load, pc_inc, pc_in, imem_req, imem_addr, instr_valid and busy decode combinationally from the state register (Moore). imem_addr is also a function of pc_value.
- PC updates on the edge ending UPDATE; FETCH sees the new pc_value.
- Minimum 4 cycles per instruction: FETCH, DECODE, EXEC, UPDATE, with ack and exec_done both arriving on their first cycle.

## Configuration
- HALT_DETECT_EN defined: an UPDATE with latched taken and target == fetch_addr (jump-to-self, the halt idiom) still performs pc_load. The FSM then → HALTED.
- In HALTED: halted=1, busy=0, no outputs active. Only reset exits.
- HALT_DETECT_EN undefined: HALTED is unreachable, halted tied to 0, and jump-to-self loops indefinitely.

## Structure
- Shared package cpu_ctrl_pkg:
  - state enum (IDLE, FETCH, DECODE, EXEC, UPDATE, HALTED)
  - WIDTH default constant 16
  - reset-value constants
- Single module, no sub-module. The pc instance lives in the CPU top and is wired to pc_reset, pc_load, pc_inc and pc_in.

## Test plan
- Reset, then run=1, imem_ack same cycle, exec_done in first EXEC cycle, no branch → PC 0→1→2→3 with exactly 4 cycles per instruction; instr matches imem_data each time.
- imem_ack delayed 3 cycles with pc_value=0x0005 → imem_req/imem_addr=0x0005 held stable 4 cycles; instr captured only on the ack edge.
- exec_done with branch_taken=1, target=0x1234 → one UPDATE cycle with pc_load=1, pc_in=0x1234, pc_inc=0; next FETCH addr=0x1234.
- run dropped during EXEC → instruction completes, PC increments once, FSM in IDLE, busy=0, no further imem_req.
- reset=0 asserted during FETCH wait → next cycle state IDLE, imem_req=0, instr=0, PC=0.
- With HALT_DETECT_EN: branch to own fetch_addr 0x0010 → halted=1 after UPDATE, PC=0x0010, no imem_req until reset. Without the macro: repeated fetches of 0x0010.
